// File: rtl/mux_pkg.sv
// mux_pkg: sizing helpers and the channel-index type shared by the stream mux and its arbiter.
package mux_pkg;
    localparam int MAX_CH = 16;
    localparam int MAX_SW = $clog2(MAX_CH);
    typedef logic [MAX_SW-1:0] ch_idx_t;
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: stateless rotating-priority arbiter; the first request at or after i_ptr wins.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  ch_idx_t      i_ptr,
    output logic [N-1:0] o_gnt,
    output ch_idx_t      o_idx,
    output logic         o_any
);
    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap_add(int'(i_ptr), k, N)]) begin
                o_gnt = '0;
                o_gnt[wrap_add(int'(i_ptr), k, N)] = 1'b1;
                o_idx = ch_idx_t'(wrap_add(int'(i_ptr), k, N));
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with fixed or round-robin selection
// and a single registered output slot.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int SW  = sel_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rr_en,
    input  logic [SW-1:0]   sel,
    input  logic [N_CH-1:0] in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0] in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready
);
    logic [SW-1:0]   r_ptr;
    logic [N_CH-1:0] w_rr_gnt;
    logic [N_CH-1:0] w_fix_gnt;
    logic [N_CH-1:0] w_gnt;
    ch_idx_t         w_rr_idx;
    logic            w_rr_any;
    logic [SW-1:0]   w_g;
    logic [SW-1:0]   w_ptr_nxt;
    logic [W-1:0]    w_data;
    logic            w_load;
    logic            w_take;

    rr_arbiter #(.N(N_CH)) u_arb (
        .i_req (in_valid),
        .i_ptr (ch_idx_t'(r_ptr)),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // An out-of-range sel shifts the bit off the end, so it grants nothing.
    assign w_fix_gnt = in_valid & (N_CH'(1) << sel);
    assign w_gnt     = rr_en ? w_rr_gnt : w_fix_gnt;
    assign w_g       = rr_en ? w_rr_idx[SW-1:0] : sel;
    assign w_load    = !out_valid || out_ready;
    assign in_ready  = (w_load && !rst) ? w_gnt : '0;
    assign w_take    = |in_ready;
    assign w_data    = W'(in_data >> (W * int'(w_g)));
    assign w_ptr_nxt = (w_g == SW'(N_CH - 1)) ? '0 : w_g + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            r_ptr     <= '0;
        end else if (w_take) begin
            out_valid <= 1'b1;
            out_data  <= w_data;
            out_ch    <= w_g;
            if (rr_en && w_rr_any) r_ptr <= w_ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
